// File: rtl/multiplicador.sv
// rtl/multiplicador.sv - sequential signed radix-2 Booth multiplier writing a 2*WIDTH-bit product to HI/LO
module multiplicador #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MultCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  // acc is one bit wider than the operands so the most negative multiplicand cannot overflow
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   mcand;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mq;
  logic             q_1;
  logic [CW-1:0]    count;
  logic             last_iter;

  assign last_iter = (count == CW'(WIDTH - 1));

  always_comb begin
    sum = acc;
    case ({mq[0], q_1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (MultCtrl) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      mcand <= '0;
      mq    <= '0;
      q_1   <= 1'b0;
      count <= '0;
      HI    <= '0;
      LO    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= MultCtrl;
          if (MultCtrl) begin
            acc   <= '0;
            mq    <= B;
            q_1   <= 1'b0;
            mcand <= {A[WIDTH-1], A};
            count <= '0;
          end
        end
        RUN: begin
          // add/subtract then arithmetic shift of {acc, mq, q_1} in one step
          acc   <= {sum[WIDTH], sum[WIDTH:1]};
          mq    <= {sum[0], mq[WIDTH-1:1]};
          q_1   <= mq[0];
          count <= count + CW'(1);
        end
        DONE: begin
          HI   <= acc[WIDTH-1:0];
          LO   <= mq;
          done <= 1'b1;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/multiplicador.md
Name: multiplicador

Overview:
- Sequential signed 32x32 multiplier for the datapath's HI/LO register pair; the counterpart of the iterative divider on the same multicycle control interface.
- Control unit pulses or holds MultCtrl; block runs radix-2 Booth over WIDTH cycles and writes the 64-bit product to HI (upper) and LO (lower).
- Exposes busy/done so the control FSM can stall until the result is valid.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits split across HI/LO.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high; clears all state and outputs
- MultCtrl  input  1  start request; sampled only in IDLE
- A  input  WIDTH  multiplicand, signed two's complement
- B  input  WIDTH  multiplier, signed two's complement
- HI  output  WIDTH  upper half of the product, registered
- LO  output  WIDTH  lower half of the product, registered
- busy  output  1  high from the cycle after start through the DONE cycle
- done  output  1  one-cycle pulse when HI/LO hold the new result

Behaviour:
- Reset (async, any state): state=IDLE; HI=0, LO=0, busy=0, done=0; count=0; product register=0. Takes effect immediately and aborts any operation in progress. HI/LO are cleared and are not partially written.
- States: IDLE, RUN, DONE.
- IDLE: done=0, busy=0. If MultCtrl=1 at edge N:
  - latch acc[WIDTH:0]=0 and mq=B, q_1=0, mcand=sign-extended A (WIDTH+1 bits), count=0;
  - go to RUN; busy=1 from edge N.
- RUN, each edge, in order:
  - examine {mq[0], q_1}: 01 -> acc = acc + mcand; 10 -> acc = acc - mcand; 00/11 -> no change.
  - Arithmetic right shift of {acc, mq, q_1} by one; acc MSB is replicated.
  - count = count + 1.
  - Go to DONE when count reaches WIDTH-1 at the edge that performs the WIDTH-th iteration (edge N+WIDTH).
- Accumulator is WIDTH+1 bits so A = -2^(WIDTH-1) never overflows.
- DONE (edge N+WIDTH+1):
  - HI = acc[WIDTH-1:0], LO = mq.
  - done=1 for exactly the cycle following this edge; busy stays 1 during that cycle.
  - Next edge returns to IDLE; done=0, busy=0.
- Latency: request sampled at edge N -> HI/LO valid and done=1 after edge N+WIDTH+1 (N+33 for WIDTH=32).
- Result equals the exact signed 64-bit product; there is no overflow or flag.
- A/B are captured at start. Changes to A, B, or MultCtrl during RUN/DONE are ignored.
- MultCtrl held high continuously: a new operation starts at the first IDLE edge, giving back-to-back ops every WIDTH+2 cycles.
- HI/LO hold their value between operations and change only in DONE or on reset.
- Zero operand: full latency is still taken and the result is 0 (no early exit).

Test Plan:
- Reset, then A=7, B=6, MultCtrl pulse at edge N -> done high after edge N+33 only; HI=0x00000000, LO=0x0000002A; busy low at N+34.
- A=-3 (0xFFFFFFFD), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Swapping the operands gives an identical result.
- A=B=0x80000000 -> HI=0x40000000, LO=0x00000000. A=B=0x7FFFFFFF -> HI=0x3FFFFFFF, LO=0x00000001.
- Start A=100, B=200; at cycle N+10, change A/B to 1/1 and toggle MultCtrl -> result is still LO=0x00004E20, HI=0. Exactly one done pulse occurs.
- Start an op and assert reset mid-cycle at N+12 -> HI=LO=0, busy=done=0 immediately. No done pulse follows. A new start after deassertion produces the correct result.
- MultCtrl held high with A=-1, B=-1 -> done pulses every 34 cycles, with HI=0, LO=1 each time.
